// File: rtl/bound_flasher_pkg.sv
// rtl/bound_flasher_pkg.sv - shared types and helpers for the bound flasher sequencer
package bound_flasher_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } run_state_e;

    typedef enum logic [1:0] {
        COUNT_DIS     = 2'd0,
        COUNT_UP_EN   = 2'd1,
        COUNT_DOWN_EN = 2'd2
    } count_state_e;

    // Phase 0 counts up and direction alternates from there.
    function automatic logic phase_is_up(input int p);
        return (p % 2) == 0;
    endfunction

endpackage

// File: rtl/led_thermo_decoder.sv
// rtl/led_thermo_decoder.sv - thermometer decode of the lit count onto the led pins
module led_thermo_decoder #(
    parameter  int NUM_LEDS = 16,
    localparam int CNT_W    = $clog2(NUM_LEDS + 1)
) (
    input  logic [CNT_W-1:0]    count,
    output logic [NUM_LEDS-1:0] led
);

    always_comb begin
        led = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            led[i] = (CNT_W'(i) < count);
        end
    end

endmodule

// File: rtl/bound_flasher_sequencer.sv
// rtl/bound_flasher_sequencer.sv - configurable phase/bound LED sequencer with kickback
module bound_flasher_sequencer
    import bound_flasher_pkg::*;
#(
    parameter int                    NUM_LEDS   = 16,
    parameter int                    NUM_PHASES = 6,
    parameter int                    CNT_W      = $clog2(NUM_LEDS + 1),
    parameter logic [NUM_PHASES-1:0] KICK_MASK  = 6'b001010,
    localparam int                   PH_W       = $clog2(NUM_PHASES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flick,
    input  logic [NUM_PHASES*CNT_W-1:0] cfg_targets,
    input  logic                        cfg_repeat,
    output logic [NUM_LEDS-1:0]         led,
    output logic [CNT_W-1:0]            count,
    output logic [PH_W-1:0]             phase,
    output logic [1:0]                  count_state,
    output logic                        busy,
    output logic                        done
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_LEDS);
    localparam logic [PH_W-1:0]  LAST_PH = PH_W'(NUM_PHASES - 1);

    if (NUM_PHASES % 2 != 0) begin : g_odd_phases
        $error("bound_flasher_sequencer: NUM_PHASES must be even");
    end

    for (genvar p = 0; p < NUM_PHASES; p += 2) begin : g_kick_chk
        if (KICK_MASK[p]) begin : g_bad_kick
            $error("bound_flasher_sequencer: KICK_MASK bit set on an up phase");
        end
    end

    run_state_e       state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             repeat_q;
    logic [CNT_W-1:0] tgt_q [NUM_PHASES];

    logic [PH_W-1:0]  prev_idx;
    logic [CNT_W-1:0] cur_tgt;
    logic [CNT_W-1:0] prev_tgt;
    logic             advance;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            repeat_q <= 1'b0;
            for (int p = 0; p < NUM_PHASES; p++) begin
                tgt_q[p] <= '0;
            end
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            count_q <= count_d;
            done_q  <= done_d;
            // Configuration is captured once per start; RUN never looks at cfg_* again.
            if (state_q == IDLE && flick) begin
                repeat_q <= cfg_repeat;
                for (int p = 0; p < NUM_PHASES; p++) begin
                    tgt_q[p] <= (cfg_targets[p*CNT_W +: CNT_W] > MAX_CNT) ?
                                MAX_CNT : cfg_targets[p*CNT_W +: CNT_W];
                end
            end
        end
    end

    always_comb begin
        prev_idx = (phase_q == '0) ? '0 : phase_q - 1'b1;
        cur_tgt  = tgt_q[phase_q];
        prev_tgt = tgt_q[prev_idx];
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        count_d = count_q;
        done_d  = 1'b0;
        advance = 1'b0;

        case (state_q)
            IDLE: begin
                count_d = '0;
                phase_d = '0;
                if (flick) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (phase_is_up(int'(phase_q))) begin
                    if (count_q >= cur_tgt) begin
                        advance = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end else begin
                    // Kickback outranks the phase end so a flick at the bound always re-arms.
                    if (KICK_MASK[phase_q] && flick && (count_q <= cur_tgt)) begin
                        count_d = prev_tgt;
                    end else if (count_q <= cur_tgt) begin
                        advance = 1'b1;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end

                if (advance) begin
                    if (phase_q == LAST_PH) begin
                        if (repeat_q) begin
                            phase_d = '0;
                        end else begin
                            state_d = IDLE;
                            phase_d = '0;
                            count_d = '0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        if (state_q == IDLE) begin
            count_state = COUNT_DIS;
        end else if (phase_is_up(int'(phase_q))) begin
            count_state = COUNT_UP_EN;
        end else begin
            count_state = COUNT_DOWN_EN;
        end
    end

    assign count = count_q;
    assign phase = phase_q;
    assign busy  = (state_q == RUN);
    assign done  = done_q;

    led_thermo_decoder #(
        .NUM_LEDS(NUM_LEDS)
    ) u_led_thermo_decoder (
        .count(count_q),
        .led  (led)
    );

endmodule

// File: tb/tb_bound_flasher_sequencer.sv
// tb/tb_bound_flasher_sequencer.sv - directed self-checking bench for bound_flasher_sequencer
module tb_bound_flasher_sequencer;
    import bound_flasher_pkg::*;

    localparam logic [29:0] TGT_A = {5'd0, 5'd5, 5'd0, 5'd10, 5'd5, 5'd16};
    localparam logic [23:0] TGT_B = {4'd0, 4'd8, 4'd1, 4'd3, 4'd9, 4'd15};
    localparam logic [23:0] TGT_C = {6'd0, 6'd20, 6'd0, 6'd32};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        flick_a, flick_b, flick_c;
    logic        rep_a;
    logic [29:0] tgt_a;

    logic [15:0] led_a;  logic [4:0] cnt_a; logic [2:0] ph_a; logic [1:0] cs_a; logic busy_a, done_a;
    logic [7:0]  led_b;  logic [3:0] cnt_b; logic [2:0] ph_b; logic [1:0] cs_b; logic busy_b, done_b;
    logic [31:0] led_c;  logic [5:0] cnt_c; logic [1:0] ph_c; logic [1:0] cs_c; logic busy_c, done_c;

    bound_flasher_sequencer #(
        .NUM_LEDS(16), .NUM_PHASES(6), .KICK_MASK(6'b001010)
    ) u_dut_a (
        .clk(clk), .rst(rst), .flick(flick_a), .cfg_targets(tgt_a), .cfg_repeat(rep_a),
        .led(led_a), .count(cnt_a), .phase(ph_a), .count_state(cs_a), .busy(busy_a), .done(done_a)
    );

    bound_flasher_sequencer #(
        .NUM_LEDS(8), .NUM_PHASES(6), .KICK_MASK(6'b001010)
    ) u_dut_b (
        .clk(clk), .rst(rst), .flick(flick_b), .cfg_targets(TGT_B), .cfg_repeat(1'b0),
        .led(led_b), .count(cnt_b), .phase(ph_b), .count_state(cs_b), .busy(busy_b), .done(done_b)
    );

    bound_flasher_sequencer #(
        .NUM_LEDS(32), .NUM_PHASES(4), .KICK_MASK(4'b1010)
    ) u_dut_c (
        .clk(clk), .rst(rst), .flick(flick_c), .cfg_targets(TGT_C), .cfg_repeat(1'b0),
        .led(led_c), .count(cnt_c), .phase(ph_c), .count_state(cs_c), .busy(busy_c), .done(done_c)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int tr_cnt  [200];
    int tr_ph   [200];
    int tr_busy [200];
    int tr_done [200];
    int tr_led  [200];
    int tr_cs   [200];
    int busy_cycles;
    int done_pulses;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Trace index k holds the outputs after edge E_k, where E0 samples the start flick.
    task automatic run_a(input int kick_k, input int glitch_k, input int ncyc);
        busy_cycles = 0;
        done_pulses = 0;
        flick_a = 1'b1;
        tick();
        flick_a = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            tr_cnt[k]  = int'(cnt_a);
            tr_ph[k]   = int'(ph_a);
            tr_busy[k] = int'(busy_a);
            tr_done[k] = int'(done_a);
            tr_led[k]  = int'(led_a);
            tr_cs[k]   = int'(cs_a);
            busy_cycles += int'(busy_a);
            done_pulses += int'(done_a);
            if (k == glitch_k) begin
                tgt_a = '0;
                rep_a = 1'b1;
            end
            flick_a = (k == kick_k);
            tick();
        end
        flick_a = 1'b0;
        if (glitch_k >= 0) begin
            tgt_a = TGT_A;
            rep_a = 1'b0;
        end
    endtask

    initial begin
        int maxc;
        int nb;
        int nd;
        longint exp_led;

        rst = 1'b1; flick_a = 1'b0; flick_b = 1'b0; flick_c = 1'b0;
        rep_a = 1'b0; tgt_a = TGT_A;
        tick();
        tick();
        check("reset_count", cnt_a, 0);
        check("reset_phase", ph_a, 0);
        check("reset_led", led_a, 0);
        check("reset_busy", busy_a, 0);
        check("reset_done", done_a, 0);
        check("reset_count_state", cs_a, COUNT_DIS);
        rst = 1'b0;
        tick();

        // Default run: 0->16->5->10->0->5->0
        run_a(-1, -1, 80);
        check("def_k0_busy", tr_busy[0], 1);
        check("def_k0_cs", tr_cs[0], COUNT_UP_EN);
        check("def_k1_cnt", tr_cnt[1], 1);
        check("def_k5_led", tr_led[5], 16'h001F);
        check("def_k16_cnt", tr_cnt[16], 16);
        check("def_k16_led", tr_led[16], 16'hFFFF);
        check("def_k17_ph", tr_ph[17], 1);
        check("def_k17_cnt", tr_cnt[17], 16);
        check("def_k17_cs", tr_cs[17], COUNT_DOWN_EN);
        check("def_k18_cnt", tr_cnt[18], 15);
        check("def_k28_cnt", tr_cnt[28], 5);
        check("def_k29_ph", tr_ph[29], 2);
        check("def_k35_cnt", tr_cnt[35], 10);
        check("def_k35_ph", tr_ph[35], 3);
        check("def_k46_ph", tr_ph[46], 4);
        check("def_k52_cnt", tr_cnt[52], 5);
        check("def_k57_ph", tr_ph[57], 5);
        check("def_k57_cnt", tr_cnt[57], 0);
        check("def_k58_done", tr_done[58], 1);
        check("def_k58_cs", tr_cs[58], COUNT_DIS);
        check("def_k59_done", tr_done[59], 0);
        check("def_k59_led", tr_led[59], 0);
        check("def_busy_cycles", busy_cycles, 58);
        check("def_done_pulses", done_pulses, 1);

        // Kickback at phase 1, count 5
        run_a(28, -1, 80);
        check("kick_k29_cnt", tr_cnt[29], 16);
        check("kick_k29_ph", tr_ph[29], 1);
        check("kick_k30_cnt", tr_cnt[30], 15);
        check("kick_k40_cnt", tr_cnt[40], 5);
        check("kick_k41_ph", tr_ph[41], 2);
        check("kick_busy_cycles", busy_cycles, 70);
        check("kick_done_pulses", done_pulses, 1);

        // Repeat mode: second pass mirrors the first
        rep_a = 1'b1;
        run_a(-1, -1, 130);
        check("rep_k57_ph", tr_ph[57], 5);
        check("rep_k58_ph", tr_ph[58], 0);
        check("rep_k58_cnt", tr_cnt[58], 0);
        check("rep_k58_busy", tr_busy[58], 1);
        check("rep_k59_cnt", tr_cnt[59], 1);
        check("rep_k75_cnt", tr_cnt[75], 16);
        check("rep_k75_ph", tr_ph[75], 1);
        check("rep_k115_ph", tr_ph[115], 5);
        check("rep_done_pulses", done_pulses, 0);
        check("rep_busy_cycles", busy_cycles, 130);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rep_a = 1'b0;
        check("rep_stop_busy", busy_a, 0);

        // Mid-run reset at count 12, with a same-cycle flick
        flick_a = 1'b1;
        tick();
        flick_a = 1'b0;
        repeat (12) tick();
        check("mid_pre_cnt", cnt_a, 12);
        rst = 1'b1;
        flick_a = 1'b1;
        tick();
        rst = 1'b0;
        flick_a = 1'b0;
        check("mid_rst_cnt", cnt_a, 0);
        check("mid_rst_phase", ph_a, 0);
        check("mid_rst_led", led_a, 0);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_done", done_a, 0);
        check("mid_rst_cs", cs_a, COUNT_DIS);
        tick();
        check("mid_after_done", done_a, 0);
        check("mid_after_busy", busy_a, 0);

        // Restart after reset; cfg changes mid-run must be ignored
        run_a(-1, 5, 80);
        check("restart_k1_cnt", tr_cnt[1], 1);
        check("restart_k17_ph", tr_ph[17], 1);
        check("restart_k17_cnt", tr_cnt[17], 16);
        check("restart_k58_done", tr_done[58], 1);
        check("restart_busy_cycles", busy_cycles, 58);
        check("restart_done_pulses", done_pulses, 1);

        // Clamp / illegal bounds on the 8-LED instance
        maxc = 0; nb = 0; nd = 0;
        flick_b = 1'b1;
        tick();
        flick_b = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (int'(cnt_b) > maxc) maxc = int'(cnt_b);
            nb += int'(busy_b);
            nd += int'(done_b);
            if (k == 8)  check("clamp_k8_cnt", cnt_b, 8);
            if (k == 9)  check("clamp_k9_ph", ph_b, 1);
            if (k == 9)  check("clamp_k9_cnt", cnt_b, 8);
            if (k == 10) check("clamp_k10_ph", ph_b, 2);
            if (k == 11) check("clamp_k11_ph", ph_b, 3);
            if (k == 11) check("clamp_k11_cnt", cnt_b, 8);
            if (k == 12) check("clamp_k12_cnt", cnt_b, 7);
            if (k == 36) check("clamp_k36_done", done_b, 1);
            tick();
        end
        check("clamp_max_cnt", maxc, 8);
        check("clamp_busy_cycles", nb, 36);
        check("clamp_done_pulses", nd, 1);

        // Parametric 32-LED, 4-phase instance
        nb = 0;
        flick_c = 1'b1;
        tick();
        flick_c = 1'b0;
        for (int k = 0; k < 120; k++) begin
            exp_led = ((64'd1 << cnt_c) - 64'd1) & 64'hFFFF_FFFF;
            check("param_thermo", led_c, exp_led);
            if (busy_c)
                check("param_dir", cs_c, ph_c[0] ? COUNT_DOWN_EN : COUNT_UP_EN);
            else
                check("param_dir_idle", cs_c, COUNT_DIS);
            nb += int'(busy_c);
            if (k == 32)  check("param_k32_cnt", cnt_c, 32);
            if (k == 33)  check("param_k33_ph", ph_c, 1);
            if (k == 66)  check("param_k66_ph", ph_c, 2);
            if (k == 87)  check("param_k87_cnt", cnt_c, 20);
            if (k == 87)  check("param_k87_ph", ph_c, 3);
            if (k == 108) check("param_k108_done", done_c, 1);
            tick();
        end
        check("param_busy_cycles", nb, 108);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bound_flasher_sequencer.md
# bound_flasher_sequencer

Parametrised successor to the fixed six-phase bound-flasher state logic. It owns the phase register, the LED counter and a thermometer LED driver. Phase bounds, phase count, kickback-enabled phases and repeat mode are all configurable. It sits between the debounced `flick` input and the LED pins, and replaces the hard-coded next-state logic with its external counter.

## Interface
- `NUM_LEDS`, default 16: number of LEDs; count range is 0..NUM_LEDS.
- `NUM_PHASES`, default 6: number of phases; must be even. Phase 0 counts up, and direction alternates after that.
- `CNT_W`, default `$clog2(NUM_LEDS+1)`: counter width.
- `KICK_MASK`, default `6'b001010`: bit p=1 enables kickback in phase p. Only down phases may set this bit.
- `clk` in 1: single clock; everything is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `flick` in 1: starts a sequence in IDLE; triggers kickback in RUN.
- `cfg_targets` in NUM_PHASES*CNT_W: phase p bound at `[p*CNT_W +: CNT_W]`. Sampled only on start.
- `cfg_repeat` in 1: loop back to phase 0 instead of returning to IDLE. Sampled only on start.
- `led` out NUM_LEDS: thermometer; `led[i] = (i < count)`.
- `count` out CNT_W: current lit count.
- `phase` out `$clog2(NUM_PHASES)`: current phase index.
- `count_state` out 2: COUNT_DIS, COUNT_UP_EN or COUNT_DOWN_EN.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse on the first IDLE cycle after a non-repeating sequence ends.

## Operation
- State machine: IDLE and RUN.
- IDLE, `flick`=1:
  - go to RUN with phase=0, count=0.
  - latch `cfg_targets` and `cfg_repeat`.
  - clamp each latched target to NUM_LEDS.
- IDLE, `flick`=0: hold. count=0, phase=0.
- RUN, up phase p (p even):
  - if count >= tgt[p], advance the phase and hold count;
  - else count+1.
- RUN, down phase p (p odd):
  - **Kickback** (highest priority): if KICK_MASK[p] and `flick` and count <= tgt[p], load count = tgt[p-1] and stay in phase p.
  - else if count <= tgt[p], advance the phase and hold count;
  - else count-1.
- Advancing from the last phase:
  - `cfg_repeat` latched=1: phase=0, count unchanged.
  - `cfg_repeat` latched=0: go to IDLE, count=0, phase=0, `done`=1 for one cycle.
- Illegal bounds (up target below count, or down target above count) give a single-cycle pass-through advance, never a wrap.
- Counter never wraps past 0 or past NUM_LEDS.
- `count_state` is decoded from the registered direction: IDLE gives DIS; even phase gives UP_EN; odd phase gives DOWN_EN.
- `flick` during an up phase or a non-kick phase is ignored.
- `cfg_*` changes during RUN have no effect.

## Timing
- Reset values: `led`=0, `count`=0, `phase`=0, `count_state`=COUNT_DIS, `busy`=0, `done`=0, state=IDLE.
- All outputs are registered or decoded from registers only. There is no combinational path from inputs to outputs.
- Start latency: `flick` sampled at edge E0 gives `busy`=1 after E0 and count=1 after E1.
- A phase transition costs one hold cycle.
- Kickback takes effect on the next edge.
- `rst` dominates everything, including a same-cycle `flick` or kickback. A reset mid-RUN returns to reset values on the next edge with no `done`.
- Simultaneous kickback and phase end: kickback wins.
- Simultaneous last-phase end and `flick`: end wins, and `flick` is not treated as a restart that cycle.

## Structure
- `bound_flasher_pkg` holds:
  - `run_state_e` (IDLE, RUN);
  - `count_state_e` (COUNT_DIS, COUNT_UP_EN, COUNT_DOWN_EN);
  - a direction helper function `phase_is_up(p)`.
- Sub-module `led_thermo_decoder` (parameter NUM_LEDS): registered count in, `led` out.
- Elaboration checks:
  - `NUM_PHASES` is even;
  - every KICK_MASK bit set is on an odd phase.

## Test plan
- **Default run**: targets {16,5,10,0,5,0}, repeat=0, single `flick` pulse.
  - count ramps 0→16→5→10→0→5→0.
  - `busy` lasts exactly 58 cycles.
  - `done` pulses once, then `led`=0.
- **Kickback**: same config, `flick` high when phase=1 and count=5.
  - Next cycle count=16, phase=1.
  - Decrement resumes.
  - Total `busy` extended by 12 cycles.
- **Repeat**: `cfg_repeat`=1.
  - After phase 5 ends, phase=0 and count=0, with no `done` and `busy` held.
  - Second pass is identical to the first.
- **Clamp/illegal**: NUM_LEDS=8, targets {15,9,3,…}.
  - phase 0 stops at 8.
  - phase 1 advances after one hold cycle with count=8.
  - No wrap.
- **Mid-run reset**: `rst` at count=12 in phase 0.
  - Next cycle all outputs are at reset values, `done`=0.
  - A subsequent `flick` restarts cleanly.
- **Parametric**: NUM_LEDS=32, NUM_PHASES=4, targets {32,0,20,0}.
  - `led` is a correct thermometer every cycle.
  - Directions alternate correctly.
